// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision adder datapath.
package fp_pkg;

  localparam int unsigned EXP_W    = 8;
  localparam int unsigned FRAC_W   = 23;
  localparam int unsigned BIAS     = 127;
  localparam int unsigned MANT_W   = FRAC_W + 1;
  localparam int unsigned STICKY_W = 3;
  localparam int unsigned ALIGN_W  = MANT_W + STICKY_W;
  localparam int unsigned WORD_W   = 1 + EXP_W + FRAC_W;

  localparam logic [WORD_W-1:0] POS_INF   = 32'h7F80_0000;
  localparam logic [WORD_W-1:0] NEG_INF   = 32'hFF80_0000;
  localparam logic [WORD_W-1:0] NAN_CANON = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, WRITE, SHOW
  } state_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } unpacked_t;

  // Split a word into sign/exp/mantissa; a zero exponent flushes to signed zero.
  function automatic unpacked_t unpack(input logic [WORD_W-1:0] w);
    unpacked_t u;
    u.sign = w[WORD_W-1];
    u.exp  = w[WORD_W-2:FRAC_W];
    u.mant = (u.exp == '0) ? '0 : {1'b1, w[FRAC_W-1:0]};
    return u;
  endfunction

endpackage

// File: rtl/fp_align_shifter.sv
// Right-shifts the smaller mantissa into {mant, G, R, S}, folding lost bits into S.
module fp_align_shifter
  import fp_pkg::*;
(
  input  logic [MANT_W-1:0]  mant,
  input  logic [EXP_W-1:0]   shamt,
  output logic [ALIGN_W-1:0] aligned_c
);

  logic [ALIGN_W-1:0] ext;
  logic [ALIGN_W-1:0] lost_mask;
  logic [4:0]         amt;

  always_comb begin
    ext       = {mant, STICKY_W'(0)};
    lost_mask = '0;
    amt       = '0;
    aligned_c = '0;
    if (shamt >= EXP_W'(ALIGN_W)) begin
      aligned_c = {(ALIGN_W-1)'(0), |mant};
    end else begin
      amt          = shamt[4:0];
      lost_mask    = ~({ALIGN_W{1'b1}} << amt);
      aligned_c    = ext >> amt;
      aligned_c[0] = aligned_c[0] | (|(ext & lost_mask));
    end
  end

endmodule

// File: rtl/fp_add_unit.sv
// Multicycle IEEE-754 single-precision adder with RNE rounding and
// denormal flush, handshaking with the operand-entry/display peripheral.
module fp_add_unit
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              inputdata_ready,
  input  logic [WORD_W-1:0] dataA,
  input  logic [WORD_W-1:0] dataB,
  output logic              loaddata,
  output logic [WORD_W-1:0] dataR,
  output logic              busy,
  output logic              done
);

  localparam int unsigned EXT_EXP_W = EXP_W + 2;
  localparam int unsigned SUM_W     = ALIGN_W + 1;

  state_e               state;
  logic [WORD_W-1:0]    a_q, b_q, res_q;
  unpacked_t            ua_q, ub_q;
  logic                 sign_q, sub_q;
  logic [EXT_EXP_W-1:0] exp_q;
  logic [ALIGN_W-1:0]   mx_q, my_q;
  logic [SUM_W-1:0]     mant_q;

  unpacked_t            ua_c, ub_c, ux_c, uy_c;
  logic                 a_nan_c, b_nan_c, a_inf_c, b_inf_c, a_ge_b_c;
  logic                 special_c;
  logic [WORD_W-1:0]    special_res_c;
  logic [EXP_W-1:0]     shamt_c;
  logic [ALIGN_W-1:0]   my_shift_c;
  logic [SUM_W-1:0]     sum_c;
  logic                 inc_c;
  logic [MANT_W:0]      rounded_c;
  logic [EXT_EXP_W-1:0] exp_rnd_c;
  logic [FRAC_W-1:0]    frac_rnd_c;

  // Special-operand classification, NaN first, then infinities, then double zero.
  always_comb begin
    ua_c          = unpack(a_q);
    ub_c          = unpack(b_q);
    a_nan_c       = (&a_q[WORD_W-2:FRAC_W]) && (|a_q[FRAC_W-1:0]);
    b_nan_c       = (&b_q[WORD_W-2:FRAC_W]) && (|b_q[FRAC_W-1:0]);
    a_inf_c       = (&a_q[WORD_W-2:FRAC_W]) && !(|a_q[FRAC_W-1:0]);
    b_inf_c       = (&b_q[WORD_W-2:FRAC_W]) && !(|b_q[FRAC_W-1:0]);
    special_c     = 1'b1;
    special_res_c = '0;
    if (a_nan_c || b_nan_c || (a_inf_c && b_inf_c && (a_q[WORD_W-1] != b_q[WORD_W-1])))
      special_res_c = NAN_CANON;
    else if (a_inf_c)
      special_res_c = a_q[WORD_W-1] ? NEG_INF : POS_INF;
    else if (b_inf_c)
      special_res_c = b_q[WORD_W-1] ? NEG_INF : POS_INF;
    else if (ua_c.exp == '0 && ub_c.exp == '0)
      special_res_c = {ua_c.sign & ub_c.sign, (WORD_W-1)'(0)};
    else
      special_c = 1'b0;
  end

  // Magnitude ordering so the subtraction never goes negative.
  always_comb begin
    a_ge_b_c = {ua_q.exp, ua_q.mant} >= {ub_q.exp, ub_q.mant};
    ux_c     = a_ge_b_c ? ua_q : ub_q;
    uy_c     = a_ge_b_c ? ub_q : ua_q;
    shamt_c  = ux_c.exp - uy_c.exp;
    sum_c    = sub_q ? ({1'b0, mx_q} - {1'b0, my_q}) : ({1'b0, mx_q} + {1'b0, my_q});
  end

  fp_align_shifter u_align (
    .mant      (uy_c.mant),
    .shamt     (shamt_c),
    .aligned_c (my_shift_c)
  );

  // Round to nearest even on {mant24, G, R, S}; a carry out renormalises by one.
  always_comb begin
    inc_c      = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
    rounded_c  = {1'b0, mant_q[ALIGN_W-1:STICKY_W]} + (MANT_W+1)'(inc_c);
    exp_rnd_c  = exp_q + EXT_EXP_W'(rounded_c[MANT_W]);
    frac_rnd_c = rounded_c[MANT_W] ? rounded_c[FRAC_W:1] : rounded_c[FRAC_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      loaddata <= 1'b1;
      dataR    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      ua_q     <= '0;
      ub_q     <= '0;
      sign_q   <= 1'b0;
      sub_q    <= 1'b0;
      exp_q    <= '0;
      mx_q     <= '0;
      my_q     <= '0;
      mant_q   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          loaddata <= 1'b1;
          if (inputdata_ready) begin
            a_q   <= dataA;
            b_q   <= dataB;
            busy  <= 1'b1;
            state <= UNPACK;
          end
        end
        UNPACK: begin
          ua_q <= ua_c;
          ub_q <= ub_c;
          if (special_c) begin
            res_q <= special_res_c;
            state <= WRITE;
          end else begin
            state <= ALIGN;
          end
        end
        ALIGN: begin
          sign_q <= ux_c.sign;
          sub_q  <= ux_c.sign ^ uy_c.sign;
          exp_q  <= EXT_EXP_W'(ux_c.exp);
          mx_q   <= {ux_c.mant, STICKY_W'(0)};
          my_q   <= my_shift_c;
          state  <= ADD;
        end
        ADD: begin
          mant_q <= sum_c;
          if (sum_c == '0) begin
            res_q <= '0;
            state <= WRITE;
          end else if (!sum_c[SUM_W-1] && sum_c[ALIGN_W-1]) begin
            state <= ROUND;
          end else begin
            state <= NORM;
          end
        end
        // One normalisation step per cycle; leaves as soon as bit 26 will be set.
        NORM: begin
          if (mant_q[SUM_W-1]) begin
            mant_q <= {1'b0, mant_q[SUM_W-1:2], mant_q[1] | mant_q[0]};
            exp_q  <= exp_q + EXT_EXP_W'(1);
            state  <= ROUND;
          end else if (exp_q == EXT_EXP_W'(1)) begin
            res_q <= {sign_q, (WORD_W-1)'(0)};
            state <= WRITE;
          end else begin
            mant_q <= mant_q << 1;
            exp_q  <= exp_q - EXT_EXP_W'(1);
            if (mant_q[ALIGN_W-2]) state <= ROUND;
          end
        end
        ROUND: begin
          if (exp_rnd_c >= EXT_EXP_W'(255))
            res_q <= sign_q ? NEG_INF : POS_INF;
          else
            res_q <= {sign_q, exp_rnd_c[EXP_W-1:0], frac_rnd_c};
          state <= WRITE;
        end
        WRITE: begin
          dataR    <= res_q;
          done     <= 1'b1;
          busy     <= 1'b0;
          loaddata <= 1'b0;
          state    <= SHOW;
        end
        SHOW: begin
          loaddata <= 1'b0;
          if (!inputdata_ready) begin
            loaddata <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_unit.sv
// Scoreboard bench for fp_add_unit: results, latencies, handshake and async reset.
module tb_fp_add_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        inputdata_ready;
  logic [31:0] dataA, dataB;
  logic        loaddata;
  logic [31:0] dataR;
  logic        busy;
  logic        done;

  typedef struct {
    logic [31:0] r;
    int          lat;
    int          e0;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  done_cnt = 0;

  fp_add_unit dut (
    .clk             (clk),
    .reset           (reset),
    .inputdata_ready (inputdata_ready),
    .dataA           (dataA),
    .dataB           (dataB),
    .loaddata        (loaddata),
    .dataR           (dataR),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every done pulse.
  always @(posedge clk) begin
    sb_t e;
    #1;
    cyc = cyc + 1;
    if (done === 1'b1) begin
      done_cnt = done_cnt + 1;
      if (sb_q.size() == 0) begin
        check_eq("spurious_done", 32'(done), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("dataR", dataR, e.r);
        if (e.lat >= 0) check_eq("latency", 32'(cyc - e.e0), 32'(e.lat));
        check_eq("loaddata_at_done", 32'(loaddata), 32'd0);
        check_eq("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input int exp_lat);
    int prev;
    @(negedge clk);
    dataA = a;
    dataB = b;
    inputdata_ready = 1'b1;
    sb_q.push_back('{r: exp_r, lat: exp_lat, e0: cyc + 1});
    prev = done_cnt;
    @(posedge clk);
    #2;
    check_eq("busy_after_e0", 32'(busy), 32'd1);
    check_eq("loaddata_entry", 32'(loaddata), 32'd1);
    dataA = ~a;
    dataB = ~b;
    for (int i = 0; i < 40; i++) begin
      if (done_cnt != prev) break;
      @(negedge clk);
    end
    if (done_cnt == prev) check_eq("done_timeout", 32'd0, 32'd1);
    prev = done_cnt;
    repeat (4) @(negedge clk);
    check_eq("no_retrigger", 32'(done_cnt), 32'(prev));
    check_eq("loaddata_show", 32'(loaddata), 32'd0);
    check_eq("dataR_held", dataR, exp_r);
    inputdata_ready = 1'b0;
    @(posedge clk);
    #2;
    check_eq("loaddata_idle", 32'(loaddata), 32'd1);
  endtask

  initial begin
    int prev;
    reset = 1'b1;
    inputdata_ready = 1'b0;
    dataA = '0;
    dataB = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_loaddata", 32'(loaddata), 32'd1);
    check_eq("rst_dataR", dataR, 32'h0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 6);
    run_op(32'h4040_0000, 32'hC000_0000, 32'h3F80_0000, 6);
    run_op(32'h3F80_0000, 32'hA1BE_867D, 32'h3F80_0000, 6);
    run_op(32'h4282_0000, 32'hC282_0000, 32'h0000_0000, -1);
    run_op(32'hC280_0000, 32'hBF80_0000, 32'hC282_0000, 5);
    run_op(32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 6);
    run_op(32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 2);
    run_op(32'h0000_0001, 32'h8000_0000, 32'h0000_0000, 2);
    run_op(32'h7FC0_1234, 32'h3F80_0000, 32'h7FC0_0000, 2);
    run_op(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 2);
    run_op(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 5);

    // Abort an operation while it is normalising.
    @(negedge clk);
    dataA = 32'h4040_0000;
    dataB = 32'hC000_0000;
    inputdata_ready = 1'b1;
    prev = done_cnt;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    inputdata_ready = 1'b0;
    #1;
    check_eq("async_rst_loaddata", 32'(loaddata), 32'd1);
    check_eq("async_rst_dataR", dataR, 32'h0);
    check_eq("async_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("no_done_after_rst", 32'(done_cnt), 32'(prev));
    check_eq("idle_after_rst", 32'(loaddata), 32'd1);

    run_op(32'h4040_0000, 32'hC000_0000, 32'h3F80_0000, 6);
    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule
